vga_write_arbiter: RTL and testbench
====================================

Name: vga_write_arbiter

Overview:
- Sits directly downstream of the picture-memory drawer and directly upstream of the VGA adapter's plot interface.
- Launches full-screen picture draws (title/win/lose) and controls the select line the drawer reads.
- Realigns the drawer's coordinates to its delayed colour data.
- Arbitrates the single VGA write port between picture draws and the game sprite path (ball/paddle/bricks).

Parameters:
PIC_LAT, 2, cycles from drawer x/y/drawing to its colour output (ROM read + colour register)
SCR_W, 160, screen width in pixels
SCR_H, 120, screen height in pixels
WAIT_MAX, 4, cycles to wait for pic_drawing to rise after pic_go before aborting

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
screen_req  in  1  pulse: request a full-screen picture draw
screen_sel  in  2  picture to draw: 0 title, 1 win, 2 lose; sampled with screen_req
pic_go  out  1  one-cycle start pulse to the drawer
pic_select  out  2  held screen select to the drawer
pic_drawing  in  1  drawer busy flag
pic_x  in  10  drawer x (0..159)
pic_y  in  10  drawer y (0..119)
pic_colour  in  3  drawer colour, valid PIC_LAT cycles after its x/y
game_valid  in  1  sprite pixel valid
game_ready  out  1  arbiter accepts sprite pixel this cycle
game_x  in  8  sprite x
game_y  in  7  sprite y
game_colour  in  3  sprite colour
vga_plot  out  1  write enable to VGA adapter
vga_x  out  8  write x
vga_y  out  7  write y
vga_colour  out  3  write colour
screen_done  out  1  one-cycle pulse when a picture draw has fully flushed
pic_abort  out  1  sticky flag: the drawer failed to start; cleared by the next screen_req
clip_count  out  8  saturating count of clipped writes (OOB_CLIP_EN only, else 0)

Behaviour:
- Reset, asynchronous while resetn=0: all outputs 0, state IDLE, delay line cleared, pending request cleared, pic_select=0.
- All vga_* outputs are registered.
- Game path:
  - game_ready = (state==IDLE) && !screen_req && !pending. Combinational.
  - A transfer occurs when game_valid && game_ready.
  - The pixel appears on vga_* with vga_plot=1 on the next cycle (latency 1).
- States:
  - IDLE:
    - screen_req or pending: pic_select<=sel, pic_go=1 for one cycle, clear pending and pic_abort, go to WAIT.
    - Otherwise serve the game path.
    - If screen_req and game_valid arrive in the same cycle, the screen request wins and the game pixel is not accepted.
  - WAIT:
    - pic_drawing=1: go to RUN.
    - WAIT_MAX cycles elapse without pic_drawing: set pic_abort, go to IDLE, no screen_done pulse.
  - RUN:
    - Each cycle, push {pic_drawing,pic_x,pic_y} into a PIC_LAT-deep shift register.
    - When the delayed drawing bit is 1: vga_plot=1, vga_x=delayed x[7:0], vga_y=delayed y[6:0], vga_colour=pic_colour.
    - When pic_drawing falls: go to FLUSH.
  - FLUSH:
    - Keep shifting for PIC_LAT cycles so the last pixel (159,119) is written.
    - Then pulse screen_done and go to IDLE.
- Pic_select is held constant from pic_go until the next request is launched, because the drawer muxes colour every cycle.
- screen_req outside IDLE:
  - Sets pending and latches screen_sel; a later request overwrites the latched select.
  - The pending request is launched on the cycle IDLE is re-entered.
- A full draw plots exactly SCR_W*SCR_H = 19200 pixels. Row-major order; each write's colour is the drawer's output for that exact address.
- A reset asserted mid-draw aborts immediately. pic_go is not re-issued after reset.

Optional Feature:
- Macro: OOB_CLIP_EN.
- Defined:
  - A write is suppressed (vga_plot stays 0) if its x>=SCR_W or y>=SCR_H. Picture path compares the full 10-bit coords; game path compares its 8/7-bit coords.
  - clip_count increments per suppressed write and saturates at 255. Cleared only by reset.
- Undefined: no comparison; coordinates are truncated to 8/7 bits and always plotted; clip_count tied to 0.

Decomposition:
- Shared package holds:
  - Screen-select constants SCR_TITLE=0, SCR_WIN=1, SCR_LOSE=2.
  - State encoding IDLE/WAIT/RUN/FLUSH.
  - SCR_W/SCR_H defaults.
- One natural sub-module: pic_align_delay. A parameterised PIC_LAT-stage shift register on {drawing, x, y}, reset to 0.

Test Plan:
- Drawer model (go -> drawing next cycle, 19200 addresses, colour = address[2:0] delayed 2): screen_req sel=1 -> pic_go one pulse, pic_select=1 held; exactly 19200 plots; pixel (x,y) has colour (y*160+x)[2:0]; last plot (159,119); screen_done one cycle after the last plot.
- Idle game_valid with (10,20,3'b101) -> game_ready=1; next cycle vga_plot=1, vga_x=10, vga_y=20, vga_colour=5.
- screen_req and game_valid in the same IDLE cycle -> game_ready=0, pic_go=1; the game pixel is plotted only after screen_done, and only while still held valid.
- Two screen_req pulses during RUN (sel=2 then sel=0) -> after screen_done, IDLE relaunches with pic_select=0; only one extra draw.
- Drawer never raises drawing -> pic_abort=1 after 4 cycles, no screen_done, game_ready=1.
- resetn low at pixel 5000 -> all outputs 0 immediately; no further plots. With OOB_CLIP_EN, game pixel (200,5) -> no plot, clip_count=1.

Source files
------------

// File: rtl/vga_write_arbiter_pkg.sv
// Shared constants and types for the VGA write arbiter and its coordinate delay line.
package vga_write_arbiter_pkg;

    localparam int unsigned SCR_W        = 160;
    localparam int unsigned SCR_H        = 120;
    localparam int unsigned PIC_LAT_DEF  = 2;
    localparam int unsigned WAIT_MAX_DEF = 4;
    localparam int unsigned COORD_W      = 10;
    localparam int unsigned COLOUR_W     = 3;
    localparam int unsigned CLIP_W       = 8;

    localparam logic [1:0] SCR_TITLE = 2'd0;
    localparam logic [1:0] SCR_WIN   = 2'd1;
    localparam logic [1:0] SCR_LOSE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // One drawer sample: busy flag plus the address it is reading.
    typedef struct packed {
        logic               drawing;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pic_tap_t;

endpackage

// File: rtl/vga_write_arbiter_align.sv
// pic_align_delay: PIC_LAT-stage shift register lining drawer x/y/drawing up with its colour.
module pic_align_delay
    import vga_write_arbiter_pkg::*;
#(
    parameter int unsigned PIC_LAT = PIC_LAT_DEF
) (
    input  logic     clk,
    input  logic     resetn,
    input  pic_tap_t din,
    output pic_tap_t dout
);

    pic_tap_t stage [PIC_LAT];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < PIC_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < PIC_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[PIC_LAT-1];

endmodule

// File: rtl/vga_write_arbiter.sv
// Launches picture draws, realigns drawer coordinates and arbitrates the VGA write port.
// Optional build macro OOB_CLIP_EN suppresses and counts off-screen writes.
module vga_write_arbiter
    import vga_write_arbiter_pkg::*;
#(
    parameter int unsigned PIC_LAT  = PIC_LAT_DEF,
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                screen_req,
    input  logic [1:0]          screen_sel,
    output logic                pic_go,
    output logic [1:0]          pic_select,
    input  logic                pic_drawing,
    input  logic [COORD_W-1:0]  pic_x,
    input  logic [COORD_W-1:0]  pic_y,
    input  logic [COLOUR_W-1:0] pic_colour,
    input  logic                game_valid,
    output logic                game_ready,
    input  logic [7:0]          game_x,
    input  logic [6:0]          game_y,
    input  logic [COLOUR_W-1:0] game_colour,
    output logic                vga_plot,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                screen_done,
    output logic                pic_abort,
    output logic [CLIP_W-1:0]   clip_count
);

    localparam int unsigned WAIT_W  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int unsigned FLUSH_W = (PIC_LAT > 1) ? $clog2(PIC_LAT) : 1;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [FLUSH_W-1:0]  flush_cnt, flush_cnt_nxt;
    logic                pending, pending_nxt;
    logic [1:0]          pend_sel, pend_sel_nxt;
    logic [1:0]          pic_select_nxt;
    logic                pic_go_nxt, pic_abort_nxt, screen_done_nxt;

    logic                wr_req;
    logic                wr_oob;
    logic [COORD_W-1:0]  wr_x, wr_y;
    logic [COLOUR_W-1:0] wr_col;

    pic_tap_t dly_in, dly_out;

    // Samples are only meaningful once a draw has been launched.
    assign dly_in = '{drawing: pic_drawing && (state != IDLE), x: pic_x, y: pic_y};

    pic_align_delay #(.PIC_LAT(PIC_LAT)) u_align (
        .clk    (clk),
        .resetn (resetn),
        .din    (dly_in),
        .dout   (dly_out)
    );

    // Next-state, launch/abort control and write-port selection.
    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        flush_cnt_nxt   = flush_cnt;
        pending_nxt     = pending;
        pend_sel_nxt    = pend_sel;
        pic_select_nxt  = pic_select;
        pic_go_nxt      = 1'b0;
        pic_abort_nxt   = pic_abort;
        screen_done_nxt = 1'b0;
        game_ready      = 1'b0;
        wr_req          = 1'b0;
        wr_x            = '0;
        wr_y            = '0;
        wr_col          = '0;

        if (state != IDLE && screen_req) begin
            pending_nxt  = 1'b1;
            pend_sel_nxt = screen_sel;
        end

        case (state)
            IDLE: begin
                if (screen_req || pending) begin
                    pic_select_nxt = screen_req ? screen_sel : pend_sel;
                    pic_go_nxt     = 1'b1;
                    pending_nxt    = 1'b0;
                    pic_abort_nxt  = 1'b0;
                    wait_cnt_nxt   = '0;
                    state_nxt      = WAIT;
                end else begin
                    game_ready = resetn;
                    if (game_valid && resetn) begin
                        wr_req = 1'b1;
                        wr_x   = COORD_W'(game_x);
                        wr_y   = COORD_W'(game_y);
                        wr_col = game_colour;
                    end
                end
            end
            WAIT: begin
                if (pic_drawing) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
                    pic_abort_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            RUN: begin
                if (!pic_drawing) begin
                    flush_cnt_nxt = '0;
                    state_nxt     = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_W'(PIC_LAT - 1)) begin
                    screen_done_nxt = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt + FLUSH_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state == RUN || state == FLUSH) && dly_out.drawing) begin
            wr_req = 1'b1;
            wr_x   = dly_out.x;
            wr_y   = dly_out.y;
            wr_col = pic_colour;
        end
    end

`ifdef OOB_CLIP_EN
    logic [CLIP_W-1:0] clip_q;

    assign wr_oob = (wr_x >= COORD_W'(SCR_W)) || (wr_y >= COORD_W'(SCR_H));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clip_q <= '0;
        end else if (wr_req && wr_oob && (clip_q != {CLIP_W{1'b1}})) begin
            clip_q <= clip_q + CLIP_W'(1);
        end
    end

    assign clip_count = clip_q;
`else
    logic unused_hi;

    assign unused_hi  = ^{wr_x[COORD_W-1:8], wr_y[COORD_W-1:7]};
    assign wr_oob     = 1'b0;
    assign clip_count = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            flush_cnt   <= '0;
            pending     <= 1'b0;
            pend_sel    <= '0;
            pic_select  <= '0;
            pic_go      <= 1'b0;
            pic_abort   <= 1'b0;
            screen_done <= 1'b0;
            vga_plot    <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            flush_cnt   <= flush_cnt_nxt;
            pending     <= pending_nxt;
            pend_sel    <= pend_sel_nxt;
            pic_select  <= pic_select_nxt;
            pic_go      <= pic_go_nxt;
            pic_abort   <= pic_abort_nxt;
            screen_done <= screen_done_nxt;
            vga_plot    <= wr_req && !wr_oob;
            if (wr_req && !wr_oob) begin
                vga_x      <= wr_x[7:0];
                vga_y      <= wr_y[6:0];
                vga_colour <= wr_col;
            end
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter with a behavioural picture drawer and plot monitor.
module tb_vga_write_arbiter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       screen_req = 1'b0;
    logic [1:0] screen_sel = 2'd0;
    logic       game_valid = 1'b0;
    logic [7:0] game_x = 8'd0;
    logic [6:0] game_y = 7'd0;
    logic [2:0] game_colour = 3'd0;

    logic       pic_go, game_ready, vga_plot, screen_done, pic_abort;
    logic [1:0] pic_select;
    logic [7:0] vga_x, clip_count;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    logic       pic_drawing;
    logic [9:0] pic_x, pic_y;
    logic [2:0] col_d1, pic_colour;
    logic       stall = 1'b0;
    logic       mon_pic = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drw_addr, mon_addr;
    int pic_plots = 0, any_plots = 0, order_err = 0, col_err = 0;
    int go_cnt = 0, done_cnt = 0, exp_addr = 0, last_addr = -1;
    int last_plot_cyc = 0, done_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_write_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .screen_req  (screen_req),
        .screen_sel  (screen_sel),
        .pic_go      (pic_go),
        .pic_select  (pic_select),
        .pic_drawing (pic_drawing),
        .pic_x       (pic_x),
        .pic_y       (pic_y),
        .pic_colour  (pic_colour),
        .game_valid  (game_valid),
        .game_ready  (game_ready),
        .game_x      (game_x),
        .game_y      (game_y),
        .game_colour (game_colour),
        .vga_plot    (vga_plot),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .screen_done (screen_done),
        .pic_abort   (pic_abort),
        .clip_count  (clip_count)
    );

    // Drawer model: go -> drawing next cycle, row-major scan, colour = address[2:0] two cycles later.
    assign drw_addr = int'(pic_y) * 160 + int'(pic_x);
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pic_drawing <= 1'b0;
            pic_x       <= 10'd0;
            pic_y       <= 10'd0;
            col_d1      <= 3'd0;
            pic_colour  <= 3'd0;
        end else begin
            col_d1     <= drw_addr[2:0];
            pic_colour <= col_d1;
            if (pic_go && !stall) begin
                pic_drawing <= 1'b1;
                pic_x       <= 10'd0;
                pic_y       <= 10'd0;
            end else if (pic_drawing) begin
                if (pic_x == 10'd159) begin
                    pic_x <= 10'd0;
                    if (pic_y == 10'd119) begin
                        pic_y       <= 10'd0;
                        pic_drawing <= 1'b0;
                    end else begin
                        pic_y <= pic_y + 10'd1;
                    end
                end else begin
                    pic_x <= pic_x + 10'd1;
                end
            end
        end
    end

    // Plot monitor: order and colour of picture writes, launch and completion pulses.
    assign mon_addr = int'(vga_y) * 160 + int'(vga_x);
    always @(negedge clk) begin
        if (pic_go) begin
            go_cnt   <= go_cnt + 1;
            exp_addr <= 0;
        end
        if (vga_plot) any_plots <= any_plots + 1;
        if (vga_plot && mon_pic) begin
            pic_plots <= pic_plots + 1;
            if (mon_addr != exp_addr) order_err <= order_err + 1;
            if (vga_colour !== mon_addr[2:0]) col_err <= col_err + 1;
            exp_addr      <= mon_addr + 1;
            last_addr     <= mon_addr;
            last_plot_cyc <= cyc;
        end
        if (screen_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (screen_done !== 1'b1 && n < 25000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(screen_done), 1);
    endtask

    initial begin
        int b_plots, b_any, b_go, b_done, b_ord, b_col, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_plot",  32'(vga_plot), 0);
        chk("rst_go",    32'(pic_go), 0);
        chk("rst_sel",   32'(pic_select), 0);
        chk("rst_ready", 32'(game_ready), 0);
        chk("rst_done",  32'(screen_done), 0);
        chk("rst_abort", 32'(pic_abort), 0);
        chk("rst_clip",  32'(clip_count), 0);
        tick();
        resetn = 1'b1;

        // Single game pixel in IDLE
        tick();
        game_valid = 1'b1; game_x = 8'd10; game_y = 7'd20; game_colour = 3'b101;
        @(negedge clk);
        chk("a_ready", 32'(game_ready), 1);
        tick();
        game_valid = 1'b0;
        @(negedge clk);
        chk("a_plot", 32'(vga_plot), 1);
        chk("a_x",    32'(vga_x), 10);
        chk("a_y",    32'(vga_y), 20);
        chk("a_col",  32'(vga_colour), 5);
        tick();
        @(negedge clk);
        chk("a_plot_off", 32'(vga_plot), 0);

        // Full draw sel=1, colliding with a held game pixel
        tick();
        mon_pic = 1'b1;
        b_plots = pic_plots; b_go = go_cnt; b_done = done_cnt; b_ord = order_err; b_col = col_err;
        screen_req = 1'b1; screen_sel = 2'd1;
        game_valid = 1'b1; game_x = 8'd30; game_y = 7'd40; game_colour = 3'b110;
        @(negedge clk);
        chk("bc_ready_low", 32'(game_ready), 0);
        tick();
        screen_req = 1'b0;
        @(negedge clk);
        chk("bc_go",     32'(pic_go), 1);
        chk("bc_sel",    32'(pic_select), 1);
        chk("bc_noplot", 32'(vga_plot), 0);
        tick();
        @(negedge clk);
        chk("bc_go_pulse", 32'(pic_go), 0);
        wait_done("bc_done");
        chk("bc_ready_after", 32'(game_ready), 1);
        tick();
        game_valid = 1'b0;
        mon_pic = 1'b0;
        @(negedge clk);
        chk("bc_gplot",      32'(vga_plot), 1);
        chk("bc_gx",         32'(vga_x), 30);
        chk("bc_gy",         32'(vga_y), 40);
        chk("bc_gcol",       32'(vga_colour), 6);
        chk("bc_done_pulse", 32'(screen_done), 0);
        chk("bc_sel_held",   32'(pic_select), 1);
        tick();
        chk("bc_plots",    32'(pic_plots - b_plots), 19200);
        chk("bc_order",    32'(order_err - b_ord), 0);
        chk("bc_colour",   32'(col_err - b_col), 0);
        chk("bc_last",     32'(last_addr), 19199);
        chk("bc_done_gap", 32'(done_cyc - last_plot_cyc), 1);
        chk("bc_go_cnt",   32'(go_cnt - b_go), 1);
        chk("bc_done_cnt", 32'(done_cnt - b_done), 1);
        @(negedge clk);
        chk("bc_gplot_off", 32'(vga_plot), 0);

        // Two requests during RUN: last select wins, exactly one relaunch
        tick();
        mon_pic = 1'b1;
        b_plots = pic_plots; b_go = go_cnt; b_done = done_cnt; b_ord = order_err; b_col = col_err;
        screen_req = 1'b1; screen_sel = 2'd1;
        tick();
        screen_req = 1'b0;
        repeat (100) tick();
        screen_req = 1'b1; screen_sel = 2'd2;
        tick();
        screen_req = 1'b0;
        @(negedge clk);
        chk("d_busy",     32'(game_ready), 0);
        chk("d_sel_held", 32'(pic_select), 1);
        repeat (50) tick();
        screen_req = 1'b1; screen_sel = 2'd0;
        tick();
        screen_req = 1'b0;
        @(negedge clk);
        wait_done("d_done1");
        chk("d_pend_ready", 32'(game_ready), 0);
        @(negedge clk);
        chk("d_relaunch", 32'(pic_go), 1);
        chk("d_resel",    32'(pic_select), 0);
        wait_done("d_done2");
        tick();
        chk("d_plots",    32'(pic_plots - b_plots), 38400);
        chk("d_order",    32'(order_err - b_ord), 0);
        chk("d_colour",   32'(col_err - b_col), 0);
        chk("d_go_cnt",   32'(go_cnt - b_go), 2);
        chk("d_done_cnt", 32'(done_cnt - b_done), 2);
        repeat (20) tick();
        chk("d_no_third",  32'(go_cnt - b_go), 2);
        chk("d_sel_final", 32'(pic_select), 0);

        // Drawer never starts: abort after four WAIT cycles
        stall = 1'b1;
        b_done = done_cnt;
        screen_req = 1'b1; screen_sel = 2'd2;
        @(negedge clk);
        chk("e_ready_low", 32'(game_ready), 0);
        tick();
        screen_req = 1'b0;
        @(negedge clk);
        chk("e_go", 32'(pic_go), 1);
        repeat (3) @(negedge clk);
        chk("e_abort_early", 32'(pic_abort), 0);
        @(negedge clk);
        chk("e_abort",       32'(pic_abort), 1);
        chk("e_ready_after", 32'(game_ready), 1);
        repeat (10) @(negedge clk);
        chk("e_abort_sticky", 32'(pic_abort), 1);
        tick();
        chk("e_no_done", 32'(done_cnt - b_done), 0);

        // Reset in the middle of a draw
        stall = 1'b0;
        b_plots = pic_plots;
        screen_req = 1'b1; screen_sel = 2'd2;
        tick();
        screen_req = 1'b0;
        @(negedge clk);
        chk("f_go",        32'(pic_go), 1);
        chk("f_abort_clr", 32'(pic_abort), 0);
        n = 0;
        while ((pic_plots - b_plots) < 5000 && n < 20000) begin
            tick();
            n++;
        end
        chk("f_reached", 32'((pic_plots - b_plots) >= 5000), 1);
        chk("f_sel_pre", 32'(pic_select), 2);
        resetn = 1'b0;
        #1;
        chk("f_plot",  32'(vga_plot), 0);
        chk("f_x",     32'(vga_x), 0);
        chk("f_y",     32'(vga_y), 0);
        chk("f_col",   32'(vga_colour), 0);
        chk("f_sel",   32'(pic_select), 0);
        chk("f_go0",   32'(pic_go), 0);
        chk("f_ready", 32'(game_ready), 0);
        chk("f_done",  32'(screen_done), 0);
        repeat (2) tick();
        resetn = 1'b1;
        b_any = any_plots; b_go = go_cnt; b_done = done_cnt;
        repeat (100) tick();
        chk("f_no_plots", 32'(any_plots - b_any), 0);
        chk("f_no_go",    32'(go_cnt - b_go), 0);
        chk("f_no_done",  32'(done_cnt - b_done), 0);

        // Off-screen and edge game pixels, back to back
        mon_pic = 1'b0;
        game_valid = 1'b1; game_x = 8'd200; game_y = 7'd5; game_colour = 3'd3;
        @(negedge clk);
        chk("g_ready", 32'(game_ready), 1);
        tick();
        game_x = 8'd159; game_y = 7'd119; game_colour = 3'd7;
        @(negedge clk);
`ifdef OOB_CLIP_EN
        chk("g_clip_plot", 32'(vga_plot), 0);
        chk("g_clip_cnt",  32'(clip_count), 1);
`else
        chk("g_oob_plot", 32'(vga_plot), 1);
        chk("g_oob_x",    32'(vga_x), 200);
        chk("g_oob_cnt",  32'(clip_count), 0);
`endif
        tick();
        game_valid = 1'b0;
        @(negedge clk);
        chk("g_edge_plot", 32'(vga_plot), 1);
        chk("g_edge_x",    32'(vga_x), 159);
        chk("g_edge_y",    32'(vga_y), 119);
        chk("g_edge_col",  32'(vga_colour), 7);
`ifdef OOB_CLIP_EN
        chk("g_edge_cnt", 32'(clip_count), 1);
`else
        chk("g_edge_cnt", 32'(clip_count), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
